// File: rtl/morse_link.sv
// morse_link - Morse loopback for bring-up and demonstration.
//   A sender keys a fixed ASCII message (A-Z) onto a one-bit Morse line.
//   A receiver on the same clock times that line, decodes each letter back
//   to ASCII, and flags when the message has ended.
//
// morse_link ports:
//   i_clk         in   1  rising-edge clock
//   i_rst         in   1  asynchronous reset, active low
//   o_data_morse  out  1  Morse line, 1 = key down
//   o_char        out  8  last decoded ASCII character
//   o_char_valid  out  1  one-cycle strobe when o_char updates
//   o_error       out  1  strobe with o_char_valid for an undecodable letter
//   o_the_end     out  1  sticky end-of-message flag
//
// morse_rx ports: i_clk, i_rst, i_line (Morse line in), plus the four
// receive outputs listed above.

package morse_link_pkg;
    // len = element count (0 = not a letter); pat right-justified, 1 = dash.
    typedef struct packed {
        logic [2:0] len;
        logic [3:0] pat;
    } code_t;

    function automatic code_t encode(logic [7:0] c);
        code_t r;
        case (c)
            "A": r = {3'd2, 4'b0001};
            "B": r = {3'd4, 4'b1000};
            "C": r = {3'd4, 4'b1010};
            "D": r = {3'd3, 4'b0100};
            "E": r = {3'd1, 4'b0000};
            "F": r = {3'd4, 4'b0010};
            "G": r = {3'd3, 4'b0110};
            "H": r = {3'd4, 4'b0000};
            "I": r = {3'd2, 4'b0000};
            "J": r = {3'd4, 4'b0111};
            "K": r = {3'd3, 4'b0101};
            "L": r = {3'd4, 4'b0100};
            "M": r = {3'd2, 4'b0011};
            "N": r = {3'd2, 4'b0010};
            "O": r = {3'd3, 4'b0111};
            "P": r = {3'd4, 4'b0110};
            "Q": r = {3'd4, 4'b1101};
            "R": r = {3'd3, 4'b0010};
            "S": r = {3'd3, 4'b0000};
            "T": r = {3'd1, 4'b0001};
            "U": r = {3'd3, 4'b0001};
            "V": r = {3'd4, 4'b0001};
            "W": r = {3'd3, 4'b0011};
            "X": r = {3'd4, 4'b1001};
            "Y": r = {3'd4, 4'b1011};
            "Z": r = {3'd4, 4'b1100};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Returns {found, ascii}; element counts above 4 never match the table.
    function automatic logic [8:0] decode(logic [2:0] len, logic [3:0] pat);
        code_t      c;
        logic [8:0] r;
        r = {1'b0, 8'h3F};
        for (int i = 0; i < 26; i++) begin
            c = encode(8'(65 + i));
            if (c.len == len && c.pat == pat) r = {1'b1, 8'(65 + i)};
        end
        return r;
    endfunction
endpackage

module morse_rx #(
    parameter int UNIT_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_line,
    output logic [7:0] o_char,
    output logic       o_char_valid,
    output logic       o_error,
    output logic       o_the_end
);
    import morse_link_pkg::*;

    // All-ones saturation value stays above every compare threshold.
    localparam int            CW      = $clog2(5*UNIT_CYCLES + 2) + 1;
    localparam logic [CW-1:0] DOT_MAX = CW'(2*UNIT_CYCLES);
    localparam logic [CW-1:0] END_RUN = CW'(5*UNIT_CYCLES);

    logic          samp;
    logic [CW-1:0] run;
    logic [3:0]    shreg;
    logic [2:0]    elem_cnt;
    logic          seen;
    logic [7:0]    dec_char;
    logic          dec_ok;

    assign {dec_ok, dec_char} = decode(elem_cnt, shreg);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            samp         <= 1'b0;
            run          <= '0;
            shreg        <= '0;
            elem_cnt     <= '0;
            seen         <= 1'b0;
            o_char       <= '0;
            o_char_valid <= 1'b0;
            o_error      <= 1'b0;
            o_the_end    <= 1'b0;
        end else begin
            samp         <= i_line;
            o_char_valid <= 1'b0;
            o_error      <= 1'b0;

            // run = cycles the sampled level has held, including this one
            if (i_line != samp)   run <= CW'(1);
            else if (run != '1)   run <= run + 1'b1;

            // end of a mark: run holds its length
            if (samp && !i_line) begin
                if (elem_cnt < 3'd4)  shreg    <= {shreg[2:0], (run > DOT_MAX)};
                if (elem_cnt != 3'd7) elem_cnt <= elem_cnt + 1'b1;
            end

            if (!samp && run == DOT_MAX && elem_cnt != 3'd0) begin
                o_char_valid <= 1'b1;
                o_char       <= dec_ok ? dec_char : 8'h3F;
                o_error      <= !dec_ok;
                elem_cnt     <= '0;
                shreg        <= '0;
                seen         <= 1'b1;
            end

            if (!samp && run == END_RUN && seen) o_the_end <= 1'b1;
        end
    end
endmodule

// Sender FSM
//   state      | meaning
//   IDLE_DONE  | before the first letter (done=0) or message finished (done=1)
//   MARK       | key down for one dot or dash
//   ELEM_GAP   | one-unit gap between elements of a letter
//   LETTER_GAP | three-unit gap after a letter, or an empty (non A-Z) letter
module morse_link #(
    parameter int                   UNIT_CYCLES = 2,
    parameter int                   MSG_LEN     = 3,
    parameter logic [8*MSG_LEN-1:0] MESSAGE     = "SOS"
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_data_morse,
    output logic [7:0] o_char,
    output logic       o_char_valid,
    output logic       o_error,
    output logic       o_the_end
);
    import morse_link_pkg::*;

    typedef enum logic [1:0] {IDLE_DONE, MARK, ELEM_GAP, LETTER_GAP} state_t;

    localparam int            TW       = $clog2(3*UNIT_CYCLES);
    localparam int            IW       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [TW-1:0] T_UNIT   = TW'(UNIT_CYCLES - 1);
    localparam logic [TW-1:0] T_DASH   = TW'(3*UNIT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LEN - 1);

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [IW-1:0] char_idx, char_idx_nxt, load_idx;
    logic [1:0]    elem_idx, elem_idx_nxt;
    logic          done, done_nxt;
    logic          start_load;
    code_t         cur_code, ld_code;

    function automatic logic [7:0] msg_char(logic [IW-1:0] idx);
        return MESSAGE[8*(MSG_LEN-1-int'(idx)) +: 8];
    endfunction

    // k counts from the first-sent element; patterns are right-justified.
    function automatic logic elem_dash(code_t c, logic [1:0] k);
        logic [1:0] pos;
        pos = c.len[1:0] - 2'd1 - k;
        return c.pat[pos];
    endfunction

    assign load_idx     = (state == IDLE_DONE) ? '0 : char_idx + 1'b1;
    assign cur_code     = encode(msg_char(char_idx));
    assign ld_code      = encode(msg_char(load_idx));
    assign o_data_morse = (state == MARK);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE_DONE;
            timer    <= '0;
            char_idx <= '0;
            elem_idx <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            char_idx <= char_idx_nxt;
            elem_idx <= elem_idx_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        char_idx_nxt = char_idx;
        elem_idx_nxt = elem_idx;
        done_nxt     = done;
        start_load   = 1'b0;

        case (state)
            IDLE_DONE: begin
                if (!done) start_load = 1'b1;
            end
            MARK: begin
                if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else if ({1'b0, elem_idx} + 3'd1 < cur_code.len) begin
                    state_nxt    = ELEM_GAP;
                    timer_nxt    = T_UNIT;
                    elem_idx_nxt = elem_idx + 1'b1;
                end else if (char_idx != LAST_IDX) begin
                    state_nxt = LETTER_GAP;
                    timer_nxt = T_DASH;
                end else begin
                    state_nxt = IDLE_DONE;
                    done_nxt  = 1'b1;
                end
            end
            ELEM_GAP: begin
                if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else begin
                    state_nxt = MARK;
                    timer_nxt = elem_dash(cur_code, elem_idx) ? T_DASH : T_UNIT;
                end
            end
            LETTER_GAP: begin
                if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else if (char_idx != LAST_IDX) begin
                    start_load = 1'b1;
                end else begin
                    state_nxt = IDLE_DONE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE_DONE;
        endcase

        // A character with no Morse code becomes a bare letter gap.
        if (start_load) begin
            char_idx_nxt = load_idx;
            elem_idx_nxt = '0;
            if (ld_code.len == 3'd0) begin
                state_nxt = LETTER_GAP;
                timer_nxt = T_DASH;
            end else begin
                state_nxt = MARK;
                timer_nxt = elem_dash(ld_code, 2'd0) ? T_DASH : T_UNIT;
            end
        end
    end

    morse_rx #(.UNIT_CYCLES(UNIT_CYCLES)) u_rx (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_line       (o_data_morse),
        .o_char       (o_char),
        .o_char_valid (o_char_valid),
        .o_error      (o_error),
        .o_the_end    (o_the_end)
    );
endmodule

// File: tb/tb_morse_link.sv
// tb_morse_link - scoreboard bench for morse_link and its receiver.
//   dut0: SOS, UNIT_CYCLES=2   dut1: ET, UNIT_CYCLES=1
//   dut2: PARIS, UNIT_CYCLES=3 rx:   morse_rx driven directly, UNIT_CYCLES=2
module tb_morse_link;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst_v   = '0;
    logic        rx_line = 1'b0;
    wire  [3:0]  line_v, valid_v, err_v, end_v;
    wire  [31:0] char_all;
    int total = 0;
    int bad   = 0;

    localparam int RXU = 2;

    morse_link dut0 (
        .i_clk(clk), .i_rst(rst_v[0]), .o_data_morse(line_v[0]), .o_char(char_all[7:0]),
        .o_char_valid(valid_v[0]), .o_error(err_v[0]), .o_the_end(end_v[0]));
    morse_link #(.UNIT_CYCLES(1), .MSG_LEN(2), .MESSAGE("ET")) dut1 (
        .i_clk(clk), .i_rst(rst_v[1]), .o_data_morse(line_v[1]), .o_char(char_all[15:8]),
        .o_char_valid(valid_v[1]), .o_error(err_v[1]), .o_the_end(end_v[1]));
    morse_link #(.UNIT_CYCLES(3), .MSG_LEN(5), .MESSAGE("PARIS")) dut2 (
        .i_clk(clk), .i_rst(rst_v[2]), .o_data_morse(line_v[2]), .o_char(char_all[23:16]),
        .o_char_valid(valid_v[2]), .o_error(err_v[2]), .o_the_end(end_v[2]));
    morse_rx #(.UNIT_CYCLES(RXU)) rx (
        .i_clk(clk), .i_rst(rst_v[3]), .i_line(rx_line), .o_char(char_all[31:24]),
        .o_char_valid(valid_v[3]), .o_error(err_v[3]), .o_the_end(end_v[3]));
    assign line_v[3] = rx_line;

    string mtab [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                         ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                         "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    typedef struct {
        int         id;
        logic [7:0] ch;
        logic       er;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   wave[$];

    task automatic chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic push_exp(int id, logic [7:0] ch, logic er);
        exp_t e;
        e.id = id;
        e.ch = ch;
        e.er = er;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (err_v[d] && !valid_v[d]) chk($sformatf("error without strobe dut%0d", d), 1, 0);
            if (valid_v[d]) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("unexpected strobe dut%0d", d), 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("strobe source", d, mon_e.id);
                    chk($sformatf("char dut%0d", d), int'(char_all[8*d +: 8]), int'(mon_e.ch));
                    chk($sformatf("error dut%0d", d), int'(err_v[d]), int'(mon_e.er));
                end
            end
        end
    end

    task automatic chk_zero(int d);
        chk($sformatf("zero line dut%0d", d), line_v[d], 0);
        chk($sformatf("zero valid dut%0d", d), valid_v[d], 0);
        chk($sformatf("zero error dut%0d", d), err_v[d], 0);
        chk($sformatf("zero the_end dut%0d", d), end_v[d], 0);
        chk($sformatf("zero char dut%0d", d), int'(char_all[8*d +: 8]), 0);
    endtask

    // Expected line, one entry per clock, from the Morse timing rules.
    task automatic build_wave(string msg, int u);
        string p;
        wave.delete();
        for (int i = 0; i < msg.len(); i++) begin
            p = mtab[int'(msg[i]) - 65];
            for (int j = 0; j < p.len(); j++) begin
                repeat ((p[j] == "-") ? 3*u : u) wave.push_back(1'b1);
                if (j < p.len() - 1) repeat (u) wave.push_back(1'b0);
            end
            if (i < msg.len() - 1) repeat (3*u) wave.push_back(1'b0);
        end
    endtask

    // Called at a negedge with rst_v[d] low; releases reset and checks.
    task automatic run_link(int d, string msg, int u, int abort_at);
        int l;
        build_wave(msg, u);
        l = wave.size();
        for (int i = 0; i < msg.len(); i++) push_exp(d, msg[i], 1'b0);
        rst_v[d] = 1'b1;
        for (int k = 0; k < l + 5*u + 8; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                rst_v[d] = 1'b0;
                #1;
                chk_zero(d);
                exp_q.delete();
                return;
            end
            chk($sformatf("line dut%0d k=%0d", d, k), line_v[d], (k < l) ? int'(wave[k]) : 0);
            chk($sformatf("the_end dut%0d k=%0d", d, k), end_v[d], (k >= l + 5*u + 1) ? 1 : 0);
        end
        chk($sformatf("chars outstanding dut%0d", d), exp_q.size(), 0);
    endtask

    task automatic model_decode(string p, output logic [7:0] c, output logic e);
        c = 8'h3F;
        e = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (mtab[i] == p) begin
                c = 8'(65 + i);
                e = 1'b0;
            end
        end
    endtask

    task automatic rx_hold(logic lvl, int n);
        rx_line = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_send(string p, int gap);
        logic [7:0] c;
        logic       e;
        model_decode(p, c, e);
        push_exp(3, c, e);
        for (int j = 0; j < p.len(); j++) begin
            if (p[j] == "-") rx_hold(1'b1, $urandom_range(4*RXU, 2*RXU + 1));
            else             rx_hold(1'b1, $urandom_range(2*RXU, 1));
            if (j < p.len() - 1) rx_hold(1'b0, $urandom_range(2*RXU - 1, 1));
        end
        rx_hold(1'b0, gap);
    endtask

    task automatic rx_reset();
        rst_v[3] = 1'b0;
        rx_line  = 1'b0;
        @(negedge clk);
        #1;
        chk_zero(3);
        @(negedge clk);
        rst_v[3] = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string p;
        int    n;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) chk_zero(d);

        run_link(0, "SOS", 2, -1);
        rst_v[0] = 1'b0;
        @(negedge clk);
        run_link(0, "SOS", 2, 20);
        repeat (3) begin
            @(negedge clk);
            chk_zero(0);
        end
        run_link(0, "SOS", 2, -1);

        run_link(1, "ET", 1, -1);
        run_link(2, "PARIS", 3, -1);

        // receiver driven directly
        rx_reset();
        push_exp(3, 8'h3F, 1'b1);
        for (int i = 0; i < 5; i++) begin
            rx_hold(1'b1, 2*RXU);
            rx_hold(1'b0, (i < 4) ? 2 : 3*RXU);
        end
        push_exp(3, "E", 1'b0);
        rx_hold(1'b1, 2*RXU);
        rx_hold(1'b0, 3*RXU);
        push_exp(3, "T", 1'b0);
        rx_hold(1'b1, 2*RXU + 1);
        rx_hold(1'b0, 3*RXU);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(9, 0) < 6) begin
                p = mtab[$urandom_range(25, 0)];
            end else begin
                p = "";
                n = $urandom_range(6, 1);
                for (int j = 0; j < n; j++) begin
                    if ($urandom_range(1, 0) == 1) p = {p, "-"};
                    else                           p = {p, "."};
                end
            end
            rx_send(p, $urandom_range(5*RXU - 1, 2*RXU));
        end
        chk("rx the_end before long gap", end_v[3], 0);
        rx_hold(1'b0, 5*RXU + 2);
        chk("rx the_end after long gap", end_v[3], 1);
        rx_send("-", 3*RXU);
        chk("rx the_end sticky after mark", end_v[3], 1);
        chk("rx chars outstanding", exp_q.size(), 0);

        rx_reset();
        rx_hold(1'b0, 1000);
        chk("rx the_end after idle low", end_v[3], 0);
        chk("rx char after idle low", int'(char_all[31:24]), 0);

        chk("scoreboard empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
